// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: serialises a 32-bit word (or an NEC repeat code) into an NEC IR frame + gap.
// Latency: tx_busy/tx_envelope rise the cycle after tx_start is accepted; every output is registered.
// Backpressure: tx_start is ignored (not queued) while tx_busy=1. Optional carrier: `define IR_CARRIER_EN.
module nec_ir_transmitter #(
  parameter int TICK_CYCLES  = 28125,
  parameter int GAP_TICKS    = 64,
  parameter int CARRIER_HALF = 658
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic        tx_repeat,
  input  logic [31:0] tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_envelope,
  output logic        irda_txd
);

  localparam int TICK_W   = $clog2(TICK_CYCLES);
  localparam int UNIT_MAX = (GAP_TICKS > 16) ? GAP_TICKS : 16;
  localparam int UNIT_W   = $clog2(UNIT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  if (TICK_CYCLES < 2 || GAP_TICKS < 1 || CARRIER_HALF < 1) begin : g_param_check
    $error("nec_ir_transmitter: TICK_CYCLES>=2, GAP_TICKS>=1, CARRIER_HALF>=1 required");
  end

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [UNIT_W-1:0] unit_cnt;
  logic [UNIT_W-1:0] unit_last;
  logic [31:0]       shift_reg;
  logic [5:0]        bit_cnt;
  logic              repeat_mode;
  logic              tick_last;
  logic              state_end;

  // Index of the final unit of the current state (length minus one).
  always_comb begin
    unit_last = '0;
    case (state)
      LEAD_MARK:  unit_last = UNIT_W'(15);
      LEAD_SPACE: unit_last = repeat_mode ? UNIT_W'(3) : UNIT_W'(7);
      BIT_SPACE:  unit_last = shift_reg[0] ? UNIT_W'(2) : UNIT_W'(0);
      GAP:        unit_last = UNIT_W'(GAP_TICKS - 1);
      default:    unit_last = '0;
    endcase
  end

  assign tick_last = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign state_end = tick_last && (unit_cnt == unit_last);

  // Frame sequencer: unit timing, bit shifting and the registered handshake/envelope outputs.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      unit_cnt    <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      repeat_mode <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_envelope <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
        unit_cnt <= '0;
        if (tx_start) begin
          shift_reg   <= tx_data;
          repeat_mode <= tx_repeat;
          bit_cnt     <= '0;
          state       <= LEAD_MARK;
          tx_busy     <= 1'b1;
          tx_envelope <= 1'b1;
        end
      end else if (state_end) begin
        tick_cnt <= '0;
        unit_cnt <= '0;
        case (state)
          LEAD_MARK: begin
            state       <= LEAD_SPACE;
            tx_envelope <= 1'b0;
          end
          LEAD_SPACE: begin
            state       <= repeat_mode ? STOP_MARK : BIT_MARK;
            tx_envelope <= 1'b1;
          end
          BIT_MARK: begin
            state       <= BIT_SPACE;
            tx_envelope <= 1'b0;
          end
          BIT_SPACE: begin
            shift_reg   <= {1'b0, shift_reg[31:1]};
            bit_cnt     <= bit_cnt + 6'd1;
            state       <= (bit_cnt == 6'd31) ? STOP_MARK : BIT_MARK;
            tx_envelope <= 1'b1;
          end
          STOP_MARK: begin
            state       <= GAP;
            tx_envelope <= 1'b0;
          end
          GAP: begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            tx_busy     <= 1'b0;
            tx_envelope <= 1'b0;
          end
        endcase
      end else if (tick_last) begin
        tick_cnt <= '0;
        unit_cnt <= unit_cnt + UNIT_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

`ifdef IR_CARRIER_EN
  localparam int CAR_W = $clog2(CARRIER_HALF + 1);

  logic [CAR_W-1:0] car_cnt;
  logic             carrier;

  // Carrier phase runs only inside marks; the space before each mark re-arms it high.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      car_cnt <= '0;
      carrier <= 1'b1;
    end else if (!tx_envelope) begin
      car_cnt <= '0;
      carrier <= 1'b1;
    end else if (car_cnt == CAR_W'(CARRIER_HALF - 1)) begin
      car_cnt <= '0;
      carrier <= ~carrier;
    end else begin
      car_cnt <= car_cnt + CAR_W'(1);
    end
  end

  assign irda_txd = tx_envelope & carrier;
`else
  assign irda_txd = tx_envelope;
`endif

endmodule
